// File: rtl/fp_normalizer.sv
// Post-add normalizer for IEEE-754 single precision: carry right-shift, iterative
// left normalization, round-to-nearest-even, and packing into a 32-bit result.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [7:0]  exponent,
  input  logic [23:0] mantissa,
  input  logic        carry_out,
  input  logic        guard,
  input  logic        round_bit,
  input  logic        sticky,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic        s_q, s_d;
  logic        c_q, c_d;
  logic [7:0]  e_q, e_d;
  logic [23:0] m_q, m_d;
  logic [2:0]  grs_q, grs_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  logic        inc;
  logic [24:0] m_sum;
  logic [23:0] m_fin;
  logic [7:0]  e_rnd;
  logic [7:0]  exp_fld;
  logic        rnd_ovf;

  // A rounding carry out of 0xFFFFFF renormalizes to 0x800000 with exponent + 1.
  assign inc     = grs_q[2] & (grs_q[1] | grs_q[0] | m_q[0]);
  assign m_sum   = {1'b0, m_q} + {24'd0, inc};
  assign m_fin   = m_sum[24] ? 24'h800000 : m_sum[23:0];
  assign e_rnd   = m_sum[24] ? e_q + 8'd1 : e_q;
  assign rnd_ovf = m_sum[24] && (e_q == 8'd254);
  assign exp_fld = !m_fin[23] ? 8'd0 : ((e_rnd == 8'd0) ? 8'd1 : e_rnd);

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    e_d      = e_q;
    m_d      = m_q;
    grs_d    = grs_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = sign;
          c_d     = carry_out;
          e_d     = exponent;
          m_d     = mantissa;
          grs_d   = {guard, round_bit, sticky};
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (c_q) begin
          m_d   = {1'b1, m_q[23:1]};
          grs_d = {m_q[0], grs_q[2], grs_q[1] | grs_q[0]};
          e_d   = e_q + 8'd1;
          if (e_q == 8'd254) begin
            result_d = {s_q, 8'hFF, 23'd0};
            ovf_d    = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = ROUND;
          end
        end else if (m_q == 24'd0 && grs_q == 3'd0) begin
          result_d = '0;
          zero_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = m_q[23] ? ROUND : SHIFT;
        end
      end
      SHIFT: begin
        if (m_q[23] || e_q <= 8'd1) begin
          state_d = ROUND;
        end else begin
          m_d   = {m_q[22:0], grs_q[2]};
          grs_d = {grs_q[1], grs_q[0], 1'b0};
          e_d   = e_q - 8'd1;
        end
      end
      ROUND: begin
        if (rnd_ovf) begin
          result_d = {s_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else begin
          result_d = {s_q, exp_fld, m_fin[22:0]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      c_q      <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      grs_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      c_q      <= c_d;
      e_q      <= e_d;
      m_q      <= m_d;
      grs_q    <= grs_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed-vector bench for fp_normalizer: result, flags and latency per vector,
// plus hold-off, ignored-input and mid-operation reset sequences.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [7:0]  exponent = '0;
  logic [23:0] mantissa = '0;
  logic        carry_out = 1'b0;
  logic        guard = 1'b0;
  logic        round_bit = 1'b0;
  logic        sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_normalizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exponent(exponent), .mantissa(mantissa), .carry_out(carry_out),
    .guard(guard), .round_bit(round_bit), .sticky(sticky),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .zero(zero)
  );

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        c;
    logic [2:0]  grs;
    logic [31:0] res;
    logic        ovf;
    logic        zr;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic start(input vec_t v);
    @(negedge clk);
    chk("in_ready_before_start", 32'(in_ready), 32'd1);
    sign      = v.s;
    exponent  = v.e;
    mantissa  = v.m;
    carry_out = v.c;
    {guard, round_bit, sticky} = v.grs;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!out_valid && cyc < 60);
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_after_accept", 32'(out_valid), 32'd0);
    chk("in_ready_after_accept", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [31:0] held;

    //              s  e      m           c  grs      result        ovf zr lat
    vecs[0]  = '{1'b0, 8'd127, 24'h000000, 1'b1, 3'b000, 32'h40000000, 1'b0, 1'b0, 2};  // 1.0+1.0
    vecs[1]  = '{1'b0, 8'd130, 24'h000000, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b1, 1};  // cancellation
    vecs[2]  = '{1'b0, 8'd127, 24'h100000, 1'b0, 3'b000, 32'h3E000000, 1'b0, 1'b0, 6};  // 3 shifts
    vecs[3]  = '{1'b0, 8'd127, 24'h800001, 1'b0, 3'b100, 32'h3F800002, 1'b0, 1'b0, 2};  // tie, odd -> up
    vecs[4]  = '{1'b0, 8'd127, 24'h800000, 1'b0, 3'b100, 32'h3F800000, 1'b0, 1'b0, 2};  // tie, even -> stay
    vecs[5]  = '{1'b1, 8'd254, 24'h000000, 1'b1, 3'b000, 32'hFF800000, 1'b1, 1'b0, 1};  // carry overflow
    vecs[6]  = '{1'b0, 8'd127, 24'hFFFFFF, 1'b0, 3'b110, 32'h40000000, 1'b0, 1'b0, 2};  // round carry
    vecs[7]  = '{1'b0, 8'd254, 24'hFFFFFF, 1'b0, 3'b100, 32'h7F800000, 1'b1, 1'b0, 2};  // round overflow
    vecs[8]  = '{1'b1, 8'd1,   24'h400000, 1'b0, 3'b000, 32'h80400000, 1'b0, 1'b0, 3};  // denormal
    vecs[9]  = '{1'b0, 8'd1,   24'h7FFFFF, 1'b0, 3'b110, 32'h00800000, 1'b0, 1'b0, 3};  // denorm -> normal
    vecs[10] = '{1'b0, 8'd127, 24'h000001, 1'b0, 3'b000, 32'h34000000, 1'b0, 1'b0, 26}; // 23 shifts
    vecs[11] = '{1'b0, 8'd127, 24'h400000, 1'b0, 3'b100, 32'h3F000001, 1'b0, 1'b0, 4};  // guard shifts in
    vecs[12] = '{1'b0, 8'd127, 24'h000003, 1'b1, 3'b000, 32'h40000002, 1'b0, 1'b0, 2};  // carry + RNE
    vecs[13] = '{1'b0, 8'd3,   24'h000000, 1'b0, 3'b001, 32'h00000000, 1'b0, 1'b0, 5};  // sticky-only, e floor

    #2;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {30'd0, overflow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      start(vecs[i]);
      wait_valid(cyc);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zr));
      accept();
    end

    // Hold-off: result stays put, in_ready low, new operands ignored.
    start(vecs[0]);
    wait_valid(cyc);
    chk("hold_first_valid", 32'(out_valid), 32'd1);
    held = result;
    @(negedge clk);
    in_valid  = 1'b1;
    exponent  = 8'd10;
    carry_out = 1'b0;
    mantissa  = 24'h000000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_result", i), result, held);
      chk($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("hold_result_value", result, 32'h40000000);
    accept();
    @(posedge clk);
    #1 chk("no_spurious_valid", 32'(out_valid), 32'd0);

    // Overflow flag cleared by the next transfer; out_ready while busy ignored.
    start(vecs[5]);
    wait_valid(cyc);
    chk("pre_reset_overflow", 32'(overflow), 32'd1);
    accept();
    out_ready = 1'b1;
    start(vecs[10]);
    chk("overflow_cleared_on_transfer", 32'(overflow), 32'd0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_flags", {30'd0, overflow, zero}, 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("postreset_in_ready", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk);
        #1 if (out_valid) seen++;
      end
      chk("postreset_no_output", 32'(seen), 32'd0);
    end

    start(vecs[2]);
    wait_valid(cyc);
    chk("recover_latency", 32'(cyc), 32'd6);
    chk("recover_result", result, 32'h3E000000);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
